// File: rtl/updown_count_sequencer_if.sv
// Requester/counter-side bundle for updown_count_sequencer.
// master = requesters plus counter datapath, slave = the sequencer.
interface updown_count_sequencer_if #(
    parameter int WIDTH = 3
);
    logic [1:0]       req;
    logic [WIDTH-1:0] tgt0;
    logic [WIDTH-1:0] tgt1;
    logic [WIDTH-1:0] cnt_q;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             err;
    logic             busy;
    logic             cnt_en;
    logic             cnt_mod;

    modport master (
        output req, tgt0, tgt1, cnt_q,
        input  gnt, done, err, busy, cnt_en, cnt_mod
    );

    modport slave (
        input  req, tgt0, tgt1, cnt_q,
        output gnt, done, err, busy, cnt_en, cnt_mod
    );
endinterface

// File: rtl/updown_count_sequencer.sv
// Round-robin sequencer that walks a shared up/down counter to a requester's
// target by the shortest modular path, then pulses done (with err on timeout).
module updown_count_sequencer #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 2**(WIDTH-1) + 2
) (
    input logic                 clk,
    input logic                 clr,
    updown_count_sequencer_if.slave bus
);
    localparam int               STEP_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] HALF      = WIDTH'(2**(WIDTH-1));
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMEOUT-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_d;
    logic              ptr, ptr_d;
    logic              g, g_d;
    logic              flag, flag_d;
    logic [WIDTH-1:0]  tgt_r, tgt_d;
    logic [STEP_W-1:0] step, step_d;
    logic [1:0]        gnt_r, gnt_d;
    logic [WIDTH-1:0]  diff;
    logic              sel;
    logic              en;
    logic              mod;

    // Distance to the target going up; anything past half-way is shorter going down.
    assign diff = tgt_r - bus.cnt_q;
    assign sel  = bus.req[ptr] ? ptr : ~ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            ptr   <= 1'b0;
            g     <= 1'b0;
            flag  <= 1'b0;
            tgt_r <= '0;
            step  <= '0;
            gnt_r <= 2'b00;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            g     <= g_d;
            flag  <= flag_d;
            tgt_r <= tgt_d;
            step  <= step_d;
            gnt_r <= gnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        g_d     = g;
        flag_d  = flag;
        tgt_d   = tgt_r;
        step_d  = step;
        gnt_d   = gnt_r;
        en      = 1'b0;
        mod     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    g_d     = sel;
                    tgt_d   = sel ? bus.tgt1 : bus.tgt0;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    step_d  = '0;
                    flag_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Withdrawal wins over everything, and gates cnt_en in the same cycle.
                if (!bus.req[g]) begin
                    gnt_d   = 2'b00;
                    ptr_d   = ~g;
                    state_d = IDLE;
                end else if (bus.cnt_q == tgt_r) begin
                    state_d = DONE;
                end else if (step == STEP_LAST) begin
                    flag_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    en     = 1'b1;
                    mod    = (diff <= HALF);
                    step_d = step + STEP_W'(1);
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                ptr_d   = ~g;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // gnt is still held in DONE, so it doubles as the one-hot done mask.
    assign bus.gnt     = gnt_r;
    assign bus.done    = (state == DONE) ? gnt_r : 2'b00;
    assign bus.err     = (state == DONE) && flag;
    assign bus.busy    = (state != IDLE);
    assign bus.cnt_en  = en;
    assign bus.cnt_mod = mod;
endmodule
